spm_seq: RTL and testbench
==========================

SPM_SEQ -- requirements
Module: spm_seq

Interface
Parameters:
REQ-001: N, default 8, operand width in bits (N >= 2); the product width is 2N.
Ports:
REQ-002: clk  input  1  sole clock; every register updates on the rising edge.
REQ-003: rst  input  1  synchronous, active-high reset.
REQ-004: start_valid  input  1  operand pair x_in/y_in is offered.
REQ-005: start_ready  output  1  block accepts operands (high only in IDLE).
REQ-006: x_in  input  N  multiplicand, signed two's complement.
REQ-007: y_in  input  N  multiplier, signed two's complement.
REQ-008: spm_x  output  N  parallel multiplicand to the serial-parallel multiplier array, held for the whole operation.
REQ-009: spm_y  output  1  serial multiplier bit to the array, LSB first.
REQ-010: spm_rst  output  1  synchronous clear of the array's carry/sum registers.
REQ-011: spm_p  input  1  serial product bit from the array.
REQ-012: res_valid  output  1  res_p holds a complete product.
REQ-013: res_ready  input  1  consumer accepts res_p.
REQ-014: res_p  output  2N  signed product x_in*y_in.
REQ-015: busy  output  1  high in every state except IDLE.

Function
REQ-016: The block SHALL implement the states IDLE, CLR, SHIFT and DONE, encoded in a single state register.
REQ-017: IDLE: start_ready=1; when start_valid=1, latch x_in into xreg and y_in into yreg, and go to CLR on the next cycle.
REQ-018: CLR: spm_rst=1 for exactly one cycle; clear the counter cnt to 0 and res_p to 0; go to SHIFT.
REQ-019: SHIFT: spm_y = yreg[cnt] for cnt < N, and spm_y = yreg[N-1] (sign extension) for N <= cnt < 2N; spm_y=0 when cnt = 2N.
REQ-020: The array has a one-cycle latency: in SHIFT with cnt >= 1, spm_p is product bit cnt-1; it SHALL be shifted into res_p at bit 2N-1, with res_p shifting right by one.
REQ-021: cnt SHALL increment by 1 each SHIFT cycle; SHIFT lasts exactly 2N+1 cycles (cnt 0..2N), then the block goes to DONE.
REQ-022: The counter width SHALL be clog2(2N+1); it never wraps during an operation.
REQ-023: DONE: res_valid=1 and res_p stable; when res_ready=1, go to IDLE on the next cycle; while res_ready=0, hold indefinitely.
REQ-024: spm_x SHALL equal xreg in every state; xreg and yreg change only on an IDLE acceptance.
REQ-025: start_valid outside IDLE SHALL be ignored (start_ready=0); no operand is queued.
REQ-026: Latency from acceptance to res_valid SHALL be 2N+3 cycles (1 for the transition to CLR, 1 for CLR, 2N+1 for SHIFT).
REQ-027: Minimum acceptance-to-acceptance interval SHALL be 2N+4 cycles when res_ready is tied high.
REQ-028: res_p SHALL equal the low 2N bits of the signed product; the overflow case x=y=-2^(N-1) yields +2^(2N-2), which is representable.
REQ-029: spm_rst, start_ready, res_valid and busy SHALL be decoded from the state only (no combinational path from inputs).

Reset
REQ-030: While rst=1 at a clock edge: state=IDLE, cnt=0, xreg=0, yreg=0, res_p=0.
REQ-031: After reset: start_ready=1, busy=0, res_valid=0, spm_y=0, spm_x=0.
REQ-032: spm_rst SHALL be 1 while rst=1, so the array is cleared together with the block.
REQ-033: rst in any state, including mid-SHIFT or in DONE with res_ready=0, SHALL abort the operation with no res_valid pulse; the partial result is discarded.

Verification (N=8, bench contains a behavioural serial-parallel multiplier with one-cycle latency)
REQ-034: x=3, y=5, res_ready=1 -> res_valid asserts 19 cycles after acceptance with res_p=0x000F, and lasts one cycle.
REQ-035: x=-3 (0xFD), y=5 -> res_p=0xFFF1; x=-128, y=-128 -> res_p=0x4000.
REQ-036: res_ready=0 for 10 cycles in DONE -> res_valid and res_p are held constant; a start_valid pulse in that window is not accepted (start_ready=0).
REQ-037: rst pulsed at cnt=7 of SHIFT -> the next cycle is IDLE with res_p=0, busy=0, spm_rst=1 during rst; the following operation x=2, y=7 gives 0x000E.
REQ-038: start_valid held high with random operands and res_ready=1 for 100 operations -> acceptances exactly 20 cycles apart, and every res_p matches the signed reference product.

Source files
------------

// File: rtl/spm_seq.sv
// spm_seq: sequencer for a bit-serial/parallel signed multiplier array.
// Feeds the multiplier LSB first with sign extension and collects the 2N-bit product.
module spm_seq #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_valid,
    output logic           start_ready,
    input  logic [N-1:0]   x_in,
    input  logic [N-1:0]   y_in,
    output logic [N-1:0]   spm_x,
    output logic           spm_y,
    output logic           spm_rst,
    input  logic           spm_p,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*N-1:0] res_p,
    output logic           busy
);
    localparam int            CW       = $clog2(2*N+1);
    localparam int            IW       = $clog2(2*N);
    localparam logic [CW-1:0] CNT_LAST = CW'(2*N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLR   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   xreg_q, xreg_d;
    logic [N-1:0]   yreg_q, yreg_d;
    logic [2*N-1:0] res_q, res_d;
    logic [2*N-1:0] y_ext;
    logic           last;

    assign y_ext = {{N{yreg_q[N-1]}}, yreg_q};
    assign last  = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            xreg_q  <= '0;
            yreg_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xreg_q  <= xreg_d;
            yreg_q  <= yreg_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_valid) state_d = CLR;
            CLR:     state_d = SHIFT;
            SHIFT:   if (last) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The array output lags spm_y by one cycle, so the cnt=0 slot carries no product bit.
    always_comb begin
        xreg_d = xreg_q;
        yreg_d = yreg_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    xreg_d = x_in;
                    yreg_d = y_in;
                end
            end
            CLR: begin
                cnt_d = '0;
                res_d = '0;
            end
            SHIFT: begin
                cnt_d = last ? '0 : cnt_q + CW'(1);
                if (cnt_q != '0) res_d = {spm_p, res_q[2*N-1:1]};
            end
            default: ;
        endcase
    end

    always_comb begin
        spm_y = 1'b0;
        if (state_q == SHIFT && !last) spm_y = y_ext[cnt_q[IW-1:0]];
    end

    // rst also clears the array so an aborted operation leaves nothing behind.
    assign spm_rst     = rst | (state_q == CLR);
    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign res_valid   = (state_q == DONE);
    assign spm_x       = xreg_q;
    assign res_p       = res_q;

endmodule

// File: tb/tb_spm_seq.sv
// Bench for spm_seq: behavioural serial-parallel multiplier array plus random
// operand streams checked against plain signed multiplication.
module tb_spm_seq;
    localparam int N = 8;

    logic           clk;
    logic           rst;
    logic           start_valid;
    logic           start_ready;
    logic [N-1:0]   x_in;
    logic [N-1:0]   y_in;
    logic [N-1:0]   spm_x;
    logic           spm_y;
    logic           spm_rst;
    logic           spm_p;
    logic           res_valid;
    logic           res_ready;
    logic [2*N-1:0] res_p;
    logic           busy;

    int n_cmp = 0;
    int n_bad = 0;

    spm_seq #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .x_in       (x_in),
        .y_in       (y_in),
        .spm_x      (spm_x),
        .spm_y      (spm_y),
        .spm_rst    (spm_rst),
        .spm_p      (spm_p),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_p      (res_p),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model: accumulate x*y_bit*2^k, emit bit k of the running sum one cycle later.
    longint acc;
    longint acc_nxt;
    int     k;
    assign acc_nxt = acc + (spm_y ? (longint'($signed(spm_x)) <<< k) : 64'sd0);

    always @(posedge clk) begin
        if (spm_rst) begin
            acc   <= 0;
            k     <= 0;
            spm_p <= 1'b0;
        end else if (k < 2*N) begin
            acc   <= acc_nxt;
            spm_p <= acc_nxt[k];
            k     <= k + 1;
        end else begin
            spm_p <= 1'b0;
        end
    end

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[2*N-1:0];
    endfunction

    function automatic logic [N-1:0] rnd_op();
        case ($urandom_range(0, 9))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'h00;
            3:       return 8'hFF;
            default: return N'($urandom);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y, input int hold, input string tag);
        int n;
        logic [2*N-1:0] e;
        e = ref_mul(x, y);
        res_ready   = (hold == 0);
        x_in        = x;
        y_in        = y;
        start_valid = 1'b1;
        chk({tag, "_rdy"}, 32'(start_ready), 1);
        step();
        start_valid = 1'b0;
        x_in = N'($urandom);
        y_in = N'($urandom);
        n = 1;
        while (!res_valid && n < 60) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, n, 19);
        chk({tag, "_p"}, 32'(res_p), 32'(e));
        chk({tag, "_x"}, 32'(spm_x), 32'(x));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                start_valid = (i == hold/2);
                x_in = N'($urandom);
                y_in = N'($urandom);
                chk({tag, "_sr"}, 32'(start_ready), 0);
                step();
                chk({tag, "_hv"}, 32'(res_valid), 1);
                chk({tag, "_hp"}, 32'(res_p), 32'(e));
            end
            start_valid = 1'b0;
            res_ready   = 1'b1;
        end
        step();
        chk({tag, "_1cyc"}, 32'(res_valid), 0);
        chk({tag, "_idle"}, 32'(start_ready), 1);
        chk({tag, "_xkeep"}, 32'(spm_x), 32'(x));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*N-1:0] q_exp[$];
        int cyc, last_acc, n_acc, n;

        rst = 1'b1; start_valid = 1'b0; res_ready = 1'b1;
        x_in = '0; y_in = '0;
        repeat (3) step();
        chk("rst_spm_rst", 32'(spm_rst), 1);
        chk("rst_ready", 32'(start_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_spm_y", 32'(spm_y), 0);
        chk("rst_spm_x", 32'(spm_x), 0);
        chk("rst_res_p", 32'(res_p), 0);
        rst = 1'b0;
        step();
        chk("post_rst_spm_rst", 32'(spm_rst), 0);

        do_op(8'h03, 8'h05, 0, "p3x5");
        do_op(8'hFD, 8'h05, 0, "m3x5");
        do_op(8'h80, 8'h80, 0, "min_sq");
        do_op(8'h7F, 8'h81, 10, "hold");

        // Abort in the middle of SHIFT (cnt=7).
        res_ready = 1'b1;
        x_in = 8'h55; y_in = 8'h33; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        repeat (8) step();
        chk("ab_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("ab_spm_rst", 32'(spm_rst), 1);
        step();
        rst = 1'b0;
        #1;
        chk("ab_busy0", 32'(busy), 0);
        chk("ab_ready", 32'(start_ready), 1);
        chk("ab_res_p", 32'(res_p), 0);
        chk("ab_valid", 32'(res_valid), 0);
        chk("ab_spm_x", 32'(spm_x), 0);
        do_op(8'h02, 8'h07, 0, "after_ab");

        // Abort while stalled in DONE.
        res_ready = 1'b0;
        x_in = 8'h12; y_in = 8'h34; start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        n = 1;
        while (!res_valid && n < 60) begin
            step();
            n++;
        end
        chk("dab_lat", n, 19);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("dab_valid", 32'(res_valid), 0);
        chk("dab_busy", 32'(busy), 0);
        chk("dab_res_p", 32'(res_p), 0);
        res_ready = 1'b1;

        // Back-to-back stream with start_valid held high.
        cyc = 0; last_acc = -1; n_acc = 0;
        x_in = rnd_op(); y_in = rnd_op(); start_valid = 1'b1;
        while ((n_acc < 100 || q_exp.size() > 0) && cyc < 2500) begin
            if (res_valid) begin
                if (q_exp.size() == 0) chk("strm_extra", 1, 0);
                else chk("strm_p", 32'(res_p), 32'(q_exp.pop_front()));
            end
            if (start_valid && start_ready) begin
                if (last_acc >= 0) chk("strm_gap", cyc - last_acc, 20);
                last_acc = cyc;
                q_exp.push_back(ref_mul(x_in, y_in));
                n_acc++;
            end
            step();
            cyc++;
            if (n_acc >= 100) start_valid = 1'b0;
            x_in = rnd_op();
            y_in = rnd_op();
        end
        if (cyc >= 2500) chk("strm_timeout", 0, 1);
        chk("strm_count", n_acc, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
